// File: rtl/uart_rx_core.sv
// Oversampling UART receiver with centre sampling, stop-bit checking and valid/ready hand-off.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
module uart_rx_core #(
    parameter int CLK_FREQ_HZ = 32_000_000,
    parameter int BAUD_RATE   = 9600,
    parameter int OVERSAMPLE  = 16,
    parameter int DATA_BITS   = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun
);
    localparam int TICK_DIV = CLK_FREQ_HZ / (BAUD_RATE * OVERSAMPLE);
    localparam int TW       = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int OW       = $clog2(OVERSAMPLE);
    localparam int BW       = $clog2(DATA_BITS);
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);
    localparam logic [OW-1:0] OS_MAX   = OW'(OVERSAMPLE - 1);
    localparam logic [OW-1:0] OS_HALF  = OW'(OVERSAMPLE / 2 - 1);
    localparam logic [BW-1:0] BIT_LAST = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;

    function automatic logic f_even_parity(input logic [DATA_BITS-1:0] d);
        return ^d;
    endfunction

    state_t                r_state;
    state_t                w_next;
    logic                  r_rx_meta, r_rx_s, r_rx_prev;
    logic [TW-1:0]         r_tick_cnt;
    logic [OW-1:0]         r_os_cnt;
    logic [BW-1:0]         r_bit_idx;
    logic [DATA_BITS-1:0]  r_shift;
    logic [DATA_BITS-1:0]  r_data;
    logic                  r_valid, r_frame_err, r_parity_err, r_overrun;
    logic                  w_tick, w_os_done, w_os_half;
    logic                  w_cnt_clr, w_shift_en, w_deliver, w_ferr, w_perr;
`ifdef UART_RX_PARITY_EN
    logic                  r_par_bad;
    logic                  w_par_sample;
`endif

    assign w_tick    = (r_state != S_IDLE) && (r_tick_cnt == TICK_MAX);
    assign w_os_done = w_tick && (r_os_cnt == OS_MAX);
    assign w_os_half = w_tick && (r_os_cnt == OS_HALF);

    // Two-stage synchroniser plus previous-sample register for falling-edge detection
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_rx_meta <= rx;
            r_rx_s    <= r_rx_meta;
            r_rx_prev <= r_rx_s;
        end
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    // Next-state and per-cycle control strobes
    always_comb begin
        w_next     = r_state;
        w_cnt_clr  = 1'b0;
        w_shift_en = 1'b0;
        w_deliver  = 1'b0;
        w_ferr     = 1'b0;
        w_perr     = 1'b0;
`ifdef UART_RX_PARITY_EN
        w_par_sample = 1'b0;
`endif
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s && r_rx_prev) begin
                    w_next    = S_START;
                    w_cnt_clr = 1'b1;
                end else begin
                    w_next = S_IDLE;
                end
            end
            S_START: begin
                if (w_os_half) begin
                    w_cnt_clr = 1'b1;
                    w_next    = r_rx_s ? S_IDLE : S_DATA;
                end else begin
                    w_next = S_START;
                end
            end
            S_DATA: begin
                if (w_os_done) begin
                    w_shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
                    w_next = (r_bit_idx == BIT_LAST) ? S_PARITY : S_DATA;
`else
                    w_next = (r_bit_idx == BIT_LAST) ? S_STOP : S_DATA;
`endif
                end else begin
                    w_next = S_DATA;
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (w_os_done) begin
                    w_par_sample = 1'b1;
                    w_next       = S_STOP;
                end else begin
                    w_next = S_PARITY;
                end
            end
`endif
            S_STOP: begin
                if (w_os_done) begin
                    if (!r_rx_s) begin
                        w_ferr = 1'b1;
                        w_next = S_BREAK;
`ifdef UART_RX_PARITY_EN
                    end else if (r_par_bad) begin
                        w_perr = 1'b1;
                        w_next = S_IDLE;
`endif
                    end else begin
                        w_deliver = 1'b1;
                        w_next    = S_IDLE;
                    end
                end else begin
                    w_next = S_STOP;
                end
            end
            S_BREAK: begin
                if (r_rx_s) w_next = S_IDLE;
                else        w_next = S_BREAK;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Baud tick divider, parked at zero while idle
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                          r_tick_cnt <= '0;
        else if (r_state == S_IDLE)       r_tick_cnt <= '0;
        else if (r_tick_cnt == TICK_MAX)  r_tick_cnt <= '0;
        else                              r_tick_cnt <= r_tick_cnt + TW'(1);
    end

    // Oversample and bit-index counters
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
        end else if (w_cnt_clr) begin
            r_os_cnt  <= '0;
            r_bit_idx <= '0;
        end else if (w_tick) begin
            r_os_cnt  <= (r_os_cnt == OS_MAX) ? '0 : r_os_cnt + OW'(1);
            r_bit_idx <= w_shift_en ? r_bit_idx + BW'(1) : r_bit_idx;
        end else begin
            r_os_cnt  <= r_os_cnt;
            r_bit_idx <= r_bit_idx;
        end
    end

    // LSB-first shift register: each new bit enters at the top
    always_ff @(posedge clk or posedge rst) begin
        if (rst)             r_shift <= '0;
        else if (w_shift_en) r_shift <= {r_rx_s, r_shift[DATA_BITS-1:1]};
        else                 r_shift <= r_shift;
    end

`ifdef UART_RX_PARITY_EN
    // Latch parity mismatch so it is judged together with the stop bit
    always_ff @(posedge clk or posedge rst) begin
        if (rst)               r_par_bad <= 1'b0;
        else if (w_par_sample) r_par_bad <= r_rx_s ^ f_even_parity(r_shift);
        else                   r_par_bad <= r_par_bad;
    end
`endif

    // Output slot, handshake and error pulses; a same-cycle consume frees the slot for a new word
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_data       <= '0;
            r_valid      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_parity_err <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_frame_err  <= w_ferr;
            r_parity_err <= w_perr;
            r_overrun    <= w_deliver && r_valid && !ready;
            if (w_deliver && (!r_valid || ready)) begin
                r_data  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && ready) begin
                r_valid <= 1'b0;
            end else begin
                r_valid <= r_valid;
            end
        end
    end

    assign data       = r_data;
    assign valid      = r_valid;
    assign frame_err  = r_frame_err;
    assign parity_err = r_parity_err;
    assign overrun    = r_overrun;
endmodule

// File: tb/tb_uart_rx_core.sv
// Scoreboard bench for uart_rx_core: frames are predicted by a frame-level model, a monitor
// compares every delivered word and error pulse against the expectation queues.
module tb_uart_rx_core;
    localparam int BIT_CLKS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk, rst, rx, ready;
    logic [7:0] data;
    logic       valid, frame_err, parity_err, overrun;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] q_data[$];
    int         q_flag[$];   // 1 frame_err, 2 parity_err, 3 overrun
    bit         model_full = 1'b0;

    uart_rx_core #(
        .CLK_FREQ_HZ(1_600_000),
        .BAUD_RATE  (100_000),
        .OVERSAMPLE (16),
        .DATA_BITS  (8)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data      (data),
        .valid     (valid),
        .ready     (ready),
        .frame_err (frame_err),
        .parity_err(parity_err),
        .overrun   (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag_seen(input int code, input string name);
        if (q_flag.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_%s: got pulse, expected none", name);
        end else begin
            check(name, code, q_flag.pop_front());
        end
    endtask

    // Frame-level reference: what one frame should produce at the consumer side
    task automatic model_frame(input logic [7:0] b, input logic stop_b, input logic par_flip);
        if (!stop_b)                    q_flag.push_back(1);
        else if (par_flip && PAR_EN)    q_flag.push_back(2);
        else if (model_full && !ready)  q_flag.push_back(3);
        else begin
            q_data.push_back(b);
            if (!ready) model_full = 1'b1;
        end
    endtask

    task automatic drive_bit(input logic b);
        rx = b;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_b, input logic par_flip,
                              input int gap);
        model_frame(b, stop_b, par_flip);
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        if (PAR_EN) drive_bit(^b ^ par_flip);
        drive_bit(stop_b);
        if (gap > 0) begin
            rx = 1'b1;
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic monitor();
        forever begin
            @(negedge clk);
            if (!rst) begin
                if (valid && ready) begin
                    if (q_data.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_data: got 0x%0h, expected no word", data);
                    end else begin
                        check("data", data, q_data.pop_front());
                    end
                end
                if (frame_err)  flag_seen(1, "frame_err");
                if (parity_err) flag_seen(2, "parity_err");
                if (overrun)    flag_seen(3, "overrun");
            end
        end
    endtask

    initial begin
        logic [7:0] b;
        logic       bad_stop, bad_par;
        int         gap;
        rst   = 1'b1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_valid", valid, 0);
        check("rst_data", data, 0);
        check("rst_frame_err", frame_err, 0);
        check("rst_parity_err", parity_err, 0);
        check("rst_overrun", overrun, 0);
        rst = 1'b0;
        fork
            monitor();
        join_none
        repeat (20) @(negedge clk);

        // 1: single frame, consumer ready
        send_frame(8'hA5, 1'b1, 1'b0, 20);

        // 2: back-to-back frames with consumer stalled, then release
        ready = 1'b0;
        send_frame(8'h3C, 1'b1, 1'b0, 0);
        send_frame(8'hC3, 1'b1, 1'b0, 40);
        ready      = 1'b1;
        model_full = 1'b0;
        repeat (20) @(negedge clk);

        // 3: bad stop bit, long break, recovery
        send_frame(8'h55, 1'b0, 1'b0, 0);
        rx = 1'b0;
        repeat (40 * BIT_CLKS) @(negedge clk);
        rx = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(8'h12, 1'b1, 1'b0, 20);

        // 4: short glitch must not start a frame
        rx = 1'b0;
        repeat (5) @(negedge clk);
        rx = 1'b1;
        repeat (3 * BIT_CLKS) @(negedge clk);
        send_frame(8'h81, 1'b1, 1'b0, 20);

        // 5: asynchronous reset in the middle of a frame
        drive_bit(1'b0);
        for (int i = 0; i < 4; i++) drive_bit(1'b1);
        repeat (5) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("midrst_valid", valid, 0);
        check("midrst_data", data, 0);
        check("midrst_frame_err", frame_err, 0);
        check("midrst_parity_err", parity_err, 0);
        check("midrst_overrun", overrun, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        repeat (2 * BIT_CLKS) @(negedge clk);
        send_frame(8'h0F, 1'b1, 1'b0, 20);

        // 6: parity good then parity bad
        if (PAR_EN) begin
            send_frame(8'h07, 1'b1, 1'b0, 20);
            send_frame(8'h07, 1'b1, 1'b1, 20);
        end

        // Randomized frames with occasional framing/parity faults
        for (int n = 0; n < 24; n++) begin
            b        = 8'($urandom_range(0, 255));
            bad_stop = ($urandom_range(0, 5) == 0);
            bad_par  = !bad_stop && ($urandom_range(0, 5) == 0);
            gap      = bad_stop ? 3 + $urandom_range(0, 20) : $urandom_range(0, 20);
            send_frame(b, !bad_stop, bad_par, gap);
        end
        rx = 1'b1;

        for (int i = 0; i < 3000 && (q_data.size() != 0 || q_flag.size() != 0); i++)
            @(negedge clk);
        repeat (100) @(negedge clk);
        check("pending_words", q_data.size(), 0);
        check("pending_flags", q_flag.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
